mem_out_master: RTL and testbench
=================================

// Module: mem_out_master
// PURPOSE
//  Initiator for the output memory: the other end of its direccion/Wen/Ren/datoEscritura/datoLectura interface.
//  Accepts one read or write request at a time from the datapath over a valid/ready handshake.
//  Drives single-cycle-clean, never-overlapping Wen/Ren strobes and returns read data as a one-cycle response pulse.
//  Sits between the Jericalla datapath store/load stage and the output memory.
// PARAMETERS
//  ADDR_W  32  width of request and memory address
//  DATA_W  32  width of data words
//  DEPTH   32  number of memory words; addresses >= DEPTH are rejected
//  RD_LAT  1   cycles Ren is held before datoLectura is captured (>=1)
// PORTS
//  clk                  in   1       single clock, rising edge
//  rst                  in   1       asynchronous, active-high reset
//  req_valid            in   1       request present
//  req_ready            out  1       controller can accept (high only in IDLE)
//  req_we               in   1       1 = write, 0 = read
//  req_dir              in   ADDR_W  word address
//  req_dato             in   DATA_W  write data
//  resp_valid           out  1       one-cycle completion pulse
//  resp_dato            out  DATA_W  read data (0 for writes/errors)
//  resp_err             out  1       address out of range (or readback mismatch, see CONFIGURATION)
//  mem_direccion        out  ADDR_W  to memory direccion
//  mem_Wen              out  1       to memory Wen
//  mem_Ren              out  1       to memory Ren
//  mem_datoEscritura    out  DATA_W  to memory datoEscritura
//  mem_datoLectura      in   DATA_W  from memory datoLectura
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE. All outputs 0 except req_ready=1. Strobes drop immediately; an in-flight op is aborted with no response.
//  - All mem_* and resp_* outputs are registered. mem_Wen && mem_Ren is never 1.
//  - States: IDLE, WRITE, READ, RESP. Transfer = req_valid && req_ready at a rising edge N; request fields are latched then.
//  - IDLE: accept. If req_dir>=DEPTH -> RESP (resp_err=1, no strobe). Else if req_we -> WRITE, otherwise -> READ.
//  - WRITE: cycle N+1 has mem_Wen=1, with mem_direccion and mem_datoEscritura already stable from edge N. -> RESP.
//    resp_valid is high in cycle N+2 with resp_dato=0.
//  - READ: mem_Ren=1 for cycles N+1..N+RD_LAT; a down-counter loaded with RD_LAT-1 tracks this.
//    mem_datoLectura is captured at the end of the last Ren cycle. resp_valid in cycle N+RD_LAT+1 with the captured data.
//  - RESP: resp_valid=1 for exactly one cycle, strobes 0 -> IDLE. req_ready rises in the cycle after the response; there are no back-to-back accepts.
//  - The address is held unchanged from accept to response; mem_direccion returns to 0 in IDLE.
//  - req_valid while busy: ignored and not lost; the source holds it until req_ready.
//  - Address compare is unsigned, full ADDR_W. The top address DEPTH-1 is valid; DEPTH is an error.
// CONFIGURATION
//  WRITE_READBACK_EN defined:
//   - After WRITE, add state VERIFY: Ren for RD_LAT cycles at the same address, compare with the written data.
//   - On mismatch, resp_err=1. Write response latency becomes RD_LAT+2 cycles after accept.
//  WRITE_READBACK_EN undefined: no VERIFY state; write response at N+2; resp_err only flags a range error.
// STRUCTURE
//  - Package mem_out_pkg holds:
//     - state enum (IDLE, WRITE, READ, VERIFY, RESP)
//     - MEM_DEPTH and word-width constants
//     - req/resp field widths
//  - One sub-module, rd_lat_cnt: loadable down-counter with a zero flag, reused by READ and VERIFY.
// TESTING
//  1. rst=1 for 2 cycles, then idle -> req_ready=1; mem_Wen, mem_Ren, resp_valid and mem_direccion all 0.
//  2. Write dir=5 dato=0xDEADBEEF -> Wen is high exactly one cycle with dir=5; resp_valid 2 cycles after accept, resp_err=0.
//  3. Read dir=5 (RD_LAT=1) -> Ren is high one cycle; resp_dato=0xDEADBEEF at accept+2. Repeat with RD_LAT=3 -> response at accept+4.
//  4. Read dir=32 (DEPTH=32) -> no strobe ever; resp_valid=1 and resp_err=1 at accept+1. dir=31 -> normal response.
//  5. Assert rst mid-READ -> Ren drops asynchronously; no resp_valid; the next request completes normally.
//  6. WRITE_READBACK_EN with a memory model forcing bit0 stuck-at-0, write 0x1 -> resp_err=1 at accept+RD_LAT+2; write 0x2 -> resp_err=0.

Source files
------------

// File: rtl/mem_out_master_pkg.sv
// Shared types and constants for the output-memory initiator.
package mem_out_pkg;

    localparam int MEM_DEPTH  = 32;
    localparam int WORD_W     = 32;
    localparam int REQ_ADDR_W = 32;
    localparam int REQ_DATA_W = WORD_W;
    localparam int RD_LAT_DEF = 1;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        VERIFY,
        RESP
    } state_e;

    // The latency counter only ever holds RD_LAT-1, so it needs clog2(RD_LAT) bits (at least one).
    function automatic int cnt_width(input int lat);
        return (lat < 2) ? 1 : $clog2(lat);
    endfunction

endpackage

// File: rtl/mem_out_master_rd_lat_cnt.sv
// Loadable down-counter with a zero flag; times the Ren window for reads and readback.
module rd_lat_cnt #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign zero = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && !zero) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_out_master.sv
// Output-memory initiator: one request at a time, clean non-overlapping Wen/Ren strobes, one-cycle response.
// Define WRITE_READBACK_EN to read back and compare every write before responding.
module mem_out_master
    import mem_out_pkg::*;
#(
    parameter int ADDR_W = REQ_ADDR_W,
    parameter int DATA_W = REQ_DATA_W,
    parameter int DEPTH  = MEM_DEPTH,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_dir,
    input  logic [DATA_W-1:0] req_dato,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_dato,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_direccion,
    output logic              mem_Wen,
    output logic              mem_Ren,
    output logic [DATA_W-1:0] mem_datoEscritura,
    input  logic [DATA_W-1:0] mem_datoLectura
);

    localparam int                CW       = cnt_width(RD_LAT);
    localparam logic [CW-1:0]     CNT_INIT = CW'(RD_LAT - 1);
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);

    state_e              state_q, state_d;
    logic                req_ready_q, req_ready_d;
    logic                resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   resp_dato_q, resp_dato_d;
    logic                resp_err_q, resp_err_d;
    logic [ADDR_W-1:0]   mem_dir_q, mem_dir_d;
    logic                wen_q, wen_d;
    logic                ren_q, ren_d;
    logic [DATA_W-1:0]   wdat_q, wdat_d;

    logic cnt_load;
    logic cnt_dec;
    logic cnt_zero;

    rd_lat_cnt #(
        .W(CW)
    ) u_rd_lat_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (CNT_INIT),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = 1'b0;
        resp_dato_d  = resp_dato_q;
        resp_err_d   = resp_err_q;
        mem_dir_d    = mem_dir_q;
        wen_d        = wen_q;
        ren_d        = ren_q;
        wdat_d       = wdat_q;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                mem_dir_d   = '0;
                wdat_d      = '0;
                resp_dato_d = '0;
                resp_err_d  = 1'b0;
                if (req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    mem_dir_d   = req_dir;
                    if (req_dir >= DEPTH_A) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (req_we) begin
                        state_d = WRITE;
                        wen_d   = 1'b1;
                        wdat_d  = req_dato;
                    end else begin
                        state_d  = READ;
                        ren_d    = 1'b1;
                        cnt_load = 1'b1;
                    end
                end
            end
            WRITE: begin
                wen_d = 1'b0;
`ifdef WRITE_READBACK_EN
                // Ren starts the cycle after Wen, so the strobes never overlap.
                state_d  = VERIFY;
                ren_d    = 1'b1;
                cnt_load = 1'b1;
`else
                state_d      = RESP;
                resp_valid_d = 1'b1;
`endif
            end
            READ: begin
                if (cnt_zero) begin
                    ren_d        = 1'b0;
                    resp_dato_d  = mem_datoLectura;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            VERIFY: begin
                if (cnt_zero) begin
                    ren_d        = 1'b0;
                    resp_err_d   = (mem_datoLectura != wdat_q);
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            RESP: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                mem_dir_d   = '0;
                wdat_d      = '0;
                resp_dato_d = '0;
                resp_err_d  = 1'b0;
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                wen_d       = 1'b0;
                ren_d       = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_dato_q  <= '0;
            resp_err_q   <= 1'b0;
            mem_dir_q    <= '0;
            wen_q        <= 1'b0;
            ren_q        <= 1'b0;
            wdat_q       <= '0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_dato_q  <= resp_dato_d;
            resp_err_q   <= resp_err_d;
            mem_dir_q    <= mem_dir_d;
            wen_q        <= wen_d;
            ren_q        <= ren_d;
            wdat_q       <= wdat_d;
        end
    end

    assign req_ready         = req_ready_q;
    assign resp_valid        = resp_valid_q;
    assign resp_dato         = resp_dato_q;
    assign resp_err          = resp_err_q;
    assign mem_direccion     = mem_dir_q;
    assign mem_Wen           = wen_q;
    assign mem_Ren           = ren_q;
    assign mem_datoEscritura = wdat_q;

endmodule

// File: tb/tb_mem_out_master.sv
// Bench for mem_out_master: two instances (RD_LAT=1 and RD_LAT=3) share stimulus, each with its own memory model.
module tb_mem_out_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_dir;
    logic [31:0] req_dato;

    logic        a_ready, a_rv, a_err, a_wen, a_ren;
    logic [31:0] a_rdato, a_dir, a_wdat, a_rdat;
    logic        b_ready, b_rv, b_err, b_wen, b_ren;
    logic [31:0] b_rdato, b_dir, b_wdat, b_rdat;

    logic [31:0] mem_a [0:31];
    logic [31:0] mem_b [0:31];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_out_master #(.ADDR_W(32), .DATA_W(32), .DEPTH(32), .RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(a_ready), .req_we(req_we),
        .req_dir(req_dir), .req_dato(req_dato), .resp_valid(a_rv), .resp_dato(a_rdato),
        .resp_err(a_err), .mem_direccion(a_dir), .mem_Wen(a_wen), .mem_Ren(a_ren),
        .mem_datoEscritura(a_wdat), .mem_datoLectura(a_rdat)
    );

    mem_out_master #(.ADDR_W(32), .DATA_W(32), .DEPTH(32), .RD_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(b_ready), .req_we(req_we),
        .req_dir(req_dir), .req_dato(req_dato), .resp_valid(b_rv), .resp_dato(b_rdato),
        .resp_err(b_err), .mem_direccion(b_dir), .mem_Wen(b_wen), .mem_Ren(b_ren),
        .mem_datoEscritura(b_wdat), .mem_datoLectura(b_rdat)
    );

    // Memory model; address 7 has bit0 stuck at 0 when readback is built in.
    function automatic logic [31:0] store_val(input logic [31:0] dir, input logic [31:0] d);
`ifdef WRITE_READBACK_EN
        if (dir == 32'd7) return d & 32'hFFFF_FFFE;
`endif
        return d;
    endfunction

    always @(posedge clk) begin
        if (a_wen && a_dir < 32) mem_a[a_dir[4:0]] <= store_val(a_dir, a_wdat);
        if (b_wen && b_dir < 32) mem_b[b_dir[4:0]] <= store_val(b_dir, b_wdat);
    end

    assign a_rdat = (a_ren && a_dir < 32) ? mem_a[a_dir[4:0]] : 32'h0;
    assign b_rdat = (b_ren && b_dir < 32) ? mem_b[b_dir[4:0]] : 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model of response latency and strobe counts.
    function automatic int exp_lat(input logic we, input logic err, input int lat);
        if (err) return 1;
`ifdef WRITE_READBACK_EN
        if (we) return lat + 2;
`else
        if (we) return 2;
`endif
        return lat + 1;
    endfunction

    function automatic int exp_ren(input logic we, input logic err, input int lat);
        if (err) return 0;
`ifdef WRITE_READBACK_EN
        if (we) return lat;
`else
        if (we) return 0;
`endif
        return lat;
    endfunction

    task automatic wait_ready();
        logic ok;
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (a_ready && b_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("ready_wait", 32'(ok), 32'd1);
    endtask

    task automatic do_req(input logic we, input logic [31:0] dir, input logic [31:0] dato,
                          input logic x_err, input logic [31:0] x_dato);
        int lat_a, lat_b, nr_a, nr_b, nw_a, nw_b, nrd_a, nrd_b, ovl, baddir, busy;
        logic e_a, e_b;
        logic [31:0] d_a, d_b;
        lat_a = 0; lat_b = 0; nr_a = 0; nr_b = 0; nw_a = 0; nw_b = 0;
        nrd_a = 0; nrd_b = 0; ovl = 0; baddir = 0; busy = 0;
        e_a = 1'bx; e_b = 1'bx; d_a = 'x; d_b = 'x;
        wait_ready();
        req_valid = 1'b1; req_we = we; req_dir = dir; req_dato = dato;
        @(posedge clk);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_valid = 1'b0;
                busy = int'(a_ready) + int'(b_ready);
            end
            if (a_rv) begin nr_a++; if (lat_a == 0) begin lat_a = k; e_a = a_err; d_a = a_rdato; end end
            if (b_rv) begin nr_b++; if (lat_b == 0) begin lat_b = k; e_b = b_err; d_b = b_rdato; end end
            if (a_wen) begin nw_a++; if (a_dir !== dir || a_wdat !== dato) baddir++; end
            if (b_wen) begin nw_b++; if (b_dir !== dir || b_wdat !== dato) baddir++; end
            if (a_ren) begin nrd_a++; if (a_dir !== dir) baddir++; end
            if (b_ren) begin nrd_b++; if (b_dir !== dir) baddir++; end
            if ((a_wen && a_ren) || (b_wen && b_ren)) ovl++;
        end
        $display("txn we=%0b dir=%0h dato=%0h: lat %0d/%0d err %0b/%0b dato %0h/%0h",
                 we, dir, dato, lat_a, lat_b, e_a, e_b, d_a, d_b);
        chk("busy_ready", 32'(busy), 32'd0);
        chk("lat_a", 32'(lat_a), 32'(exp_lat(we, x_err, 1)));
        chk("lat_b", 32'(lat_b), 32'(exp_lat(we, x_err, 3)));
        chk("npulse_a", 32'(nr_a), 32'd1);
        chk("npulse_b", 32'(nr_b), 32'd1);
        chk("err_a", 32'(e_a), 32'(x_err));
        chk("err_b", 32'(e_b), 32'(x_err));
        chk("dato_a", d_a, x_dato);
        chk("dato_b", d_b, x_dato);
        chk("wen_a", 32'(nw_a), (we && !(dir >= 32)) ? 32'd1 : 32'd0);
        chk("wen_b", 32'(nw_b), (we && !(dir >= 32)) ? 32'd1 : 32'd0);
        chk("ren_a", 32'(nrd_a), 32'(exp_ren(we, dir >= 32, 1)));
        chk("ren_b", 32'(nrd_b), 32'(exp_ren(we, dir >= 32, 3)));
        chk("strobe_addr", 32'(baddir), 32'd0);
        chk("overlap", 32'(ovl), 32'd0);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] dir;
        logic [31:0] dato;
        logic        exp_err;
        logic [31:0] exp_dato;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int nresp;
        vecs.push_back('{1'b1, 32'd5,          32'hDEADBEEF, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'd5,          32'h0,        1'b0, 32'hDEADBEEF});
        vecs.push_back('{1'b0, 32'd32,         32'h0,        1'b1, 32'h0});
        vecs.push_back('{1'b1, 32'd31,         32'h12345678, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'd31,         32'h0,        1'b0, 32'h12345678});
        vecs.push_back('{1'b0, 32'hFFFF_FFFF,  32'h0,        1'b1, 32'h0});
        vecs.push_back('{1'b1, 32'd0,          32'hA5A5A5A5, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'd0,          32'h0,        1'b0, 32'hA5A5A5A5});
        vecs.push_back('{1'b1, 32'd33,         32'hFFFFFFFF, 1'b1, 32'h0});
        vecs.push_back('{1'b0, 32'd5,          32'h0,        1'b0, 32'hDEADBEEF});
`ifdef WRITE_READBACK_EN
        vecs.push_back('{1'b1, 32'd7,          32'h1,        1'b1, 32'h0});
        vecs.push_back('{1'b1, 32'd7,          32'h2,        1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'd7,          32'h0,        1'b0, 32'h2});
`endif

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_dir = '0; req_dato = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'({a_ready, b_ready}), 32'd3);
        chk("rst_strobes", 32'({a_wen, a_ren, b_wen, b_ren}), 32'd0);
        chk("rst_resp", 32'({a_rv, b_rv}), 32'd0);
        chk("rst_dir_a", a_dir, 32'd0);
        chk("rst_dir_b", b_dir, 32'd0);

        foreach (vecs[i])
            do_req(vecs[i].we, vecs[i].dir, vecs[i].dato, vecs[i].exp_err, vecs[i].exp_dato);

        // Reset in the middle of a read: strobe drops at once and no response follows.
        wait_ready();
        req_valid = 1'b1; req_we = 1'b0; req_dir = 32'd5;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("midread_ren", 32'({a_ren, b_ren}), 32'd3);
        rst = 1'b1;
        #1;
        chk("async_ren_drop", 32'({a_ren, b_ren}), 32'd0);
        chk("async_ready", 32'({a_ready, b_ready}), 32'd3);
        nresp = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 2) rst = 1'b0;
            if (a_rv || b_rv) nresp++;
        end
        $display("txn reset mid-read: responses after abort %0d", nresp);
        chk("abort_no_resp", 32'(nresp), 32'd0);
        do_req(1'b0, 32'd5, 32'h0, 1'b0, 32'hDEADBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
